// File: rtl/alu_arbiter.sv
// alu_arbiter: lets two requesters take turns on one shared combinational ALU.
//
// Each operation runs through three phases:
//    accept  - the request is latched (cycle N)
//    execute - the ALU result is captured (cycle N+1)
//    respond - the captured result is offered (from cycle N+2 until taken)
//
// Build option:
//    ALU_ARB_RR_EN defined   - round-robin tie-break. The requester that was
//                              not granted last time wins a tie.
//    ALU_ARB_RR_EN undefined - fixed priority. Requester 0 wins every tie.
//
// Ports:
//    CLK, nRST                  clock; asynchronous active-low reset
//    req_valid/req_ready        per-requester request handshake (ready is one-hot or zero)
//    req_op, req_a, req_b       per-requester opcode and operands
//    rsp_valid/rsp_ready        per-requester response handshake (valid is one-hot or zero)
//    rsp_result, rsp_flags      registered result and {overflow, zero, negative}
//    alu_op, alu_a, alu_b       operands to the shared ALU, driven only from the latches
//    alu_result, alu_negative,
//    alu_zero, alu_overflow     outputs of the shared ALU
//    busy                       high whenever the arbiter is not idle

package cpu_types_pkg;
   localparam int WORD_W = 32;
   typedef logic [3:0] aluop_t;
   localparam aluop_t ALU_ADD = 4'h0;
   localparam aluop_t ALU_SUB = 4'h1;
   localparam aluop_t ALU_AND = 4'h2;
   localparam aluop_t ALU_OR  = 4'h3;
   localparam aluop_t ALU_XOR = 4'h4;
endpackage

// state | meaning
// IDLE  | waiting for a request; the winner's req_ready is raised combinationally
// EXEC  | latched operation drives the ALU; its result is captured at the end of the cycle
// RESP  | rsp_valid[grant] is held until rsp_ready[grant] is seen
module alu_arbiter #(
   parameter int  WORD_W = cpu_types_pkg::WORD_W,
   localparam int NREQ   = 2
) (
   input  logic                                CLK,
   input  logic                                nRST,
   input  logic [NREQ-1:0]                     req_valid,
   output logic [NREQ-1:0]                     req_ready,
   input  cpu_types_pkg::aluop_t [NREQ-1:0]    req_op,
   input  logic [NREQ-1:0][WORD_W-1:0]         req_a,
   input  logic [NREQ-1:0][WORD_W-1:0]         req_b,
   output logic [NREQ-1:0]                     rsp_valid,
   input  logic [NREQ-1:0]                     rsp_ready,
   output logic [WORD_W-1:0]                   rsp_result,
   output logic [2:0]                          rsp_flags,
   output cpu_types_pkg::aluop_t               alu_op,
   output logic [WORD_W-1:0]                   alu_a,
   output logic [WORD_W-1:0]                   alu_b,
   input  logic [WORD_W-1:0]                   alu_result,
   input  logic                                alu_negative,
   input  logic                                alu_zero,
   input  logic                                alu_overflow,
   output logic                                busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic                  last_grant;
   logic                  winner;
   logic                  accept;
   cpu_types_pkg::aluop_t op_q;
   logic [WORD_W-1:0]     a_q, b_q;

   // Only the tie case depends on the build option; a lone requester always wins.
   always_comb begin
      winner = 1'b0;
      if (req_valid == 2'b10) begin
         winner = 1'b1;
      end else if (req_valid == 2'b11) begin
`ifdef ALU_ARB_RR_EN
         winner = ~last_grant;
`else
         winner = 1'b0;
`endif
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= IDLE;
      else       state <= state_nxt;
   end

   // nRST gates req_ready. The state register is already IDLE during reset,
   // so without the gate a valid request could still see ready while reset is low.
   always_comb begin
      state_nxt = state;
      req_ready = '0;
      rsp_valid = '0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (|req_valid) begin
               accept            = nRST;
               req_ready[winner] = nRST;
               state_nxt         = EXEC;
            end
         end
         EXEC: state_nxt = RESP;
         RESP: begin
            rsp_valid[last_grant] = 1'b1;
            if (rsp_ready[last_grant]) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // last_grant also serves as the grant index of the operation in flight.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         last_grant <= 1'b1;
         op_q       <= 4'b0000;
         a_q        <= '0;
         b_q        <= '0;
         rsp_result <= '0;
         rsp_flags  <= '0;
      end else begin
         if (accept) begin
            last_grant <= winner;
            op_q       <= req_op[winner];
            a_q        <= req_a[winner];
            b_q        <= req_b[winner];
         end
         if (state == EXEC) begin
            rsp_result <= alu_result;
            rsp_flags  <= {alu_overflow, alu_zero, alu_negative};
         end
      end
   end

   assign alu_op = op_q;
   assign alu_a  = a_q;
   assign alu_b  = b_q;
   assign busy   = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter. The shared ALU is modelled here. Every
// expected value is a hand-computed constant.
module tb_alu_arbiter;

   logic                        CLK;
   logic                        nRST;
   logic [1:0]                  req_valid;
   logic [1:0]                  req_ready;
   cpu_types_pkg::aluop_t [1:0] req_op;
   logic [1:0][31:0]            req_a;
   logic [1:0][31:0]            req_b;
   logic [1:0]                  rsp_valid;
   logic [1:0]                  rsp_ready;
   logic [31:0]                 rsp_result;
   logic [2:0]                  rsp_flags;
   cpu_types_pkg::aluop_t       alu_op;
   logic [31:0]                 alu_a, alu_b, alu_result;
   logic                        alu_negative, alu_zero, alu_overflow;
   logic                        busy;

   int n_cmp = 0;
   int n_mis = 0;
   int exp_g;
   logic ov_seen;

   alu_arbiter dut (
      .CLK          (CLK),
      .nRST         (nRST),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_a        (req_a),
      .req_b        (req_b),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_result   (rsp_result),
      .rsp_flags    (rsp_flags),
      .alu_op       (alu_op),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_result   (alu_result),
      .alu_negative (alu_negative),
      .alu_zero     (alu_zero),
      .alu_overflow (alu_overflow),
      .busy         (busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Combinational ALU model.
   always_comb begin
      alu_result   = '0;
      alu_overflow = 1'b0;
      case (alu_op)
         cpu_types_pkg::ALU_ADD: begin
            alu_result   = alu_a + alu_b;
            alu_overflow = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
         end
         cpu_types_pkg::ALU_SUB: begin
            alu_result   = alu_a - alu_b;
            alu_overflow = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
         end
         default: alu_result = '0;
      endcase
      alu_negative = alu_result[31];
      alu_zero     = (alu_result == '0);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      nRST      = 1'b0;
      req_valid = 2'b01;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 2'b00;
      #3;
      chk("rst req_ready",  32'(req_ready), 0);
      chk("rst rsp_valid",  32'(rsp_valid), 0);
      chk("rst busy",       32'(busy), 0);
      chk("rst rsp_result", rsp_result, 0);
      chk("rst rsp_flags",  32'(rsp_flags), 0);
      chk("rst alu_op",     32'(alu_op), 0);
      chk("rst alu_a",      alu_a, 0);
      chk("rst alu_b",      alu_b, 0);

      // ADD 5+7 from requester 0, accepted in the first cycle out of reset.
      cyc();
      cyc();
      req_op[0] = cpu_types_pkg::ALU_ADD;
      req_a[0]  = 32'd5;
      req_b[0]  = 32'd7;
      nRST      = 1'b1;
      #1;
      chk("add accept ready", 32'(req_ready), 1);
      chk("add accept busy",  32'(busy), 0);
      chk("add no comb alu",  alu_a, 0);
      cyc();
      req_valid = 2'b00;
      req_a[0]  = 32'd99;
      #1;
      chk("add exec busy",      32'(busy), 1);
      chk("add exec ready",     32'(req_ready), 0);
      chk("add exec rsp_valid", 32'(rsp_valid), 0);
      chk("add exec alu_a",     alu_a, 5);
      chk("add exec alu_b",     alu_b, 7);
      cyc();
      rsp_ready = 2'b01;
      #1;
      chk("add resp valid",  32'(rsp_valid), 1);
      chk("add resp result", rsp_result, 12);
      chk("add resp flags",  32'(rsp_flags), 0);
      cyc();
      rsp_ready = 2'b00;
      #1;
      chk("add idle busy",  32'(busy), 0);
      chk("add idle valid", 32'(rsp_valid), 0);

      // Both requesters held valid; reset first so the grant history is fresh.
      nRST = 1'b0;
      #1;
      nRST      = 1'b1;
      req_valid = 2'b11;
      req_op[0] = cpu_types_pkg::ALU_ADD;
      req_a[0]  = 32'd1;
      req_b[0]  = 32'd2;
      req_op[1] = cpu_types_pkg::ALU_SUB;
      req_a[1]  = 32'd10;
      req_b[1]  = 32'd4;
      rsp_ready = 2'b11;
      #1;
      for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
         exp_g = i % 2;
`else
         exp_g = 0;
`endif
         chk("tie ready", 32'(req_ready), 32'(1 << exp_g));
         cyc();
         chk("tie exec ready", 32'(req_ready), 0);
         chk("tie exec busy",  32'(busy), 1);
         cyc();
         chk("tie resp valid",  32'(rsp_valid), 32'(1 << exp_g));
         chk("tie resp result", rsp_result, (exp_g == 1) ? 32'd6 : 32'd3);
         cyc();
      end
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      #1;

      // Requester 1 SUB 3-3; requester 1 is slow to take the result.
      req_valid = 2'b10;
      req_op[1] = cpu_types_pkg::ALU_SUB;
      req_a[1]  = 32'd3;
      req_b[1]  = 32'd3;
      #1;
      chk("sub single ready", 32'(req_ready), 2);
      cyc();
      req_valid = 2'b00;
      #1;
      chk("sub exec alu_op", 32'(alu_op), 32'(cpu_types_pkg::ALU_SUB));
      chk("sub exec alu_a",  alu_a, 3);
      cyc();
      req_valid = 2'b01;
      rsp_ready = 2'b01;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("sub hold valid",  32'(rsp_valid), 2);
         chk("sub hold result", rsp_result, 0);
         chk("sub hold flags",  32'(rsp_flags), 2);
         chk("sub hold ready",  32'(req_ready), 0);
         cyc();
      end
      rsp_ready = 2'b10;
      req_valid = 2'b00;
      #1;
      chk("sub release valid", 32'(rsp_valid), 2);
      cyc();
      rsp_ready = 2'b00;
      #1;
      chk("sub back idle busy",  32'(busy), 0);
      chk("sub back idle valid", 32'(rsp_valid), 0);

      // Reset while in EXEC aborts the operation.
      req_valid = 2'b01;
      req_op[0] = cpu_types_pkg::ALU_ADD;
      req_a[0]  = 32'd2;
      req_b[0]  = 32'd2;
      #1;
      chk("abort accept ready", 32'(req_ready), 1);
      cyc();
      req_valid = 2'b11;
      nRST      = 1'b0;
      #1;
      chk("abort ready", 32'(req_ready), 0);
      chk("abort valid", 32'(rsp_valid), 0);
      chk("abort busy",  32'(busy), 0);
      chk("abort alu_a", alu_a, 0);
      chk("abort flags", 32'(rsp_flags), 0);
      req_valid = 2'b00;
      #2;
      nRST = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("abort no resp", 32'(rsp_valid), 0);
         chk("abort no busy", 32'(busy), 0);
      end

      // Signed overflow on ADD 0x7FFFFFFF + 1.
      req_valid = 2'b01;
      req_op[0] = cpu_types_pkg::ALU_ADD;
      req_a[0]  = 32'h7FFF_FFFF;
      req_b[0]  = 32'd1;
      #1;
      chk("ovf accept ready", 32'(req_ready), 1);
      cyc();
      req_valid = 2'b00;
      #1;
      chk("ovf exec alu_a", alu_a, 32'h7FFF_FFFF);
      ov_seen = alu_overflow;
      cyc();
      rsp_ready = 2'b01;
      #1;
      chk("ovf resp valid",  32'(rsp_valid), 1);
      chk("ovf resp result", rsp_result, 32'h8000_0000);
      chk("ovf resp flags",  32'(rsp_flags), 5);
      chk("ovf flag copy",   32'(rsp_flags[2]), 32'(ov_seen));
      cyc();
      rsp_ready = 2'b00;
      #1;
      chk("ovf idle busy", 32'(busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WORD_W, 32 (taken from cpu_types_pkg), data word width.
REQ-002 Parameter: NREQ, 2 (fixed, not overridable), number of requesters.
REQ-003 Port: CLK  in  1  rising-edge clock.
REQ-004 Port: nRST  in  1  asynchronous active-low reset.
REQ-005 Port: req_valid  in  2  per-requester operation request.
REQ-006 Port: req_ready  out  2  per-requester accept; one-hot or zero.
REQ-007 Port: req_op  in  2x4 (aluop_t)  per-requester ALU opcode.
REQ-008 Port: req_a, req_b  in  2xWORD_W each  per-requester operands.
REQ-009 Port: rsp_valid  out  2  per-requester result valid; one-hot or zero.
REQ-010 Port: rsp_ready  in  2  per-requester result accept.
REQ-011 Port: rsp_result  out  WORD_W  registered ALU result, shared by both requesters.
REQ-012 Port: rsp_flags  out  3  registered {overflow, zero, negative}.
REQ-013 Port: alu_op  out  4; alu_a, alu_b  out  WORD_W  drive the shared ALU.
REQ-014 Port: alu_result  in  WORD_W; alu_negative, alu_zero, alu_overflow  in  1 each  ALU outputs (combinational ALU).
REQ-015 Port: busy  out  1  high in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, EXEC, RESP; exactly one active at all times.
REQ-017 IDLE: if any req_valid is high, the arbiter selects a winner, asserts req_ready[winner] combinationally in the same cycle, latches op/a/b and the grant index, and moves to EXEC on the next edge.
REQ-018 IDLE with no req_valid: req_ready=0, remain in IDLE.
REQ-019 EXEC: alu_op/alu_a/alu_b are driven from the latched registers; at the end of the cycle alu_result and flags are captured into rsp_result/rsp_flags; move to RESP.
REQ-020 RESP: rsp_valid[grant]=1; hold rsp_result/rsp_flags stable until rsp_ready[grant]=1, then return to IDLE on that edge.
REQ-021 Latency: request accepted at edge N -> rsp_valid high in cycle N+2 (two cycles after the accept cycle); throughput at most one operation per 3 cycles.
REQ-022 req_ready is low in EXEC and RESP; requesters hold req_valid and operands stable until they see req_ready.
REQ-023 rsp_ready on the non-granted requester is ignored.
REQ-024 alu_* outputs always reflect the latched registers (also in IDLE/RESP); no combinational path from req_* to alu_*.
REQ-025 Arbitration: simultaneous req_valid=2'b11 resolves per REQ-034/REQ-035; a single valid requester always wins.
REQ-026 Grant register last_grant updates only on an accepted request.
REQ-027 Result width: rsp_result is alu_result[WORD_W-1:0] unmodified; flags are copied unmodified.

Reset
REQ-028 nRST low asynchronously forces state=IDLE, last_grant=1, latched op=4'b0000, latched a/b=0, rsp_result=0, rsp_flags=0.
REQ-029 While nRST is low: req_ready=0, rsp_valid=0, busy=0.
REQ-030 Reset asserted in EXEC or RESP aborts the operation; no response is ever issued for it.
REQ-031 After nRST deasserts, the first accepted request may occur in the first clock cycle.

Configuration
REQ-032 Macro ALU_ARB_RR_EN selects the arbitration policy.
REQ-033 All other behaviour is identical with and without the macro.
REQ-034 With ALU_ARB_RR_EN defined: round-robin; on a tie the requester not equal to last_grant wins (first tie after reset goes to requester 0).
REQ-035 Without ALU_ARB_RR_EN: fixed priority; requester 0 always wins a tie; last_grant is still maintained but unused.

Verification
REQ-036 Reset, then req_valid=01, op=ADD, a=5, b=7 -> req_ready=01 that cycle; two cycles later rsp_valid=01, rsp_result=12, rsp_flags=3'b000.
REQ-037 req_valid=11 held continuously, rsp_ready=11 -> RR build: grants alternate 0,1,0,1; fixed build: every grant goes to 0, requester 1 is never granted.
REQ-038 Requester 1 SUB a=3, b=3 with rsp_ready low for 4 cycles -> rsp_valid=10 held, rsp_result=0, zero flag=1, stable all 4 cycles; return to IDLE one edge after rsp_ready[1]=1.
REQ-039 Pulse nRST low during EXEC -> immediately req_ready=0, rsp_valid=0, busy=0; no rsp_valid ever appears for the aborted operation.
REQ-040 Requester 0 ADD a=32'h7FFFFFFF, b=1 -> rsp_result=32'h80000000, negative=1; rsp_flags overflow bit equals alu_overflow as sampled in EXEC.
